// File: rtl/mult_pkg.sv
// Shared sizing defaults and shift-direction type for the sequential multiplier datapath.
package mult_pkg;

    localparam int DEF_IN_W    = 8;
    localparam int DEF_LEFT_W  = 14;
    localparam int DEF_RIGHT_W = 8;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/dir_shift_reg.sv
// Loadable one-direction logical shift register; load wins over shift_en, zero fill on shift.
module dir_shift_reg
    import mult_pkg::*;
#(
    parameter int   WIDTH = DEF_LEFT_W,
    parameter int   IN_W  = DEF_IN_W,
    parameter dir_e DIR   = SHIFT_LEFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [IN_W-1:0]  d_in,
    output logic [WIDTH-1:0] q
);

    generate
        if (WIDTH < IN_W) begin : g_width_check
            $error("dir_shift_reg: WIDTH must be >= IN_W");
        end
    endgenerate

    // Bits pushed out of either end are dropped, so repeated shifts saturate at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= WIDTH'(d_in);
        end else if (shift_en) begin
            if (DIR == SHIFT_LEFT) begin
                q <= q << 1;
            end else begin
                q <= q >> 1;
            end
        end
    end

endmodule

// File: rtl/operand_shift_unit.sv
// Paired multiplicand/multiplier shifters with current-bit and done decode for the multiplier controller.
module operand_shift_unit
    import mult_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int LEFT_W  = DEF_LEFT_W,
    parameter int RIGHT_W = DEF_RIGHT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IN_W-1:0]    left_in,
    input  logic [IN_W-1:0]    right_in,
    input  logic               load,
    input  logic               shift_en,
    output logic [LEFT_W-1:0]  left_out,
    output logic [RIGHT_W-1:0] right_out,
    output logic               right_lsb,
    output logic               right_zero
);

    // load and shift_en are level commands sampled every rising edge; there is no handshake.
    dir_shift_reg #(
        .WIDTH (LEFT_W),
        .IN_W  (IN_W),
        .DIR   (SHIFT_LEFT)
    ) u_left (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .d_in     (left_in),
        .q        (left_out)
    );

    dir_shift_reg #(
        .WIDTH (RIGHT_W),
        .IN_W  (IN_W),
        .DIR   (SHIFT_RIGHT)
    ) u_right (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .d_in     (right_in),
        .q        (right_out)
    );

    assign right_lsb  = right_out[0];
    assign right_zero = (right_out == '0);

endmodule

// File: tb/tb_operand_shift_unit.sv
// Directed bench for operand_shift_unit: expected outputs queued per command, checked by a monitor.
module tb_operand_shift_unit;

    localparam int IN_W    = 8;
    localparam int LEFT_W  = 14;
    localparam int RIGHT_W = 8;
    localparam int EXP_W   = LEFT_W + RIGHT_W + 2;

    logic               clk;
    logic               rst;
    logic [IN_W-1:0]    left_in;
    logic [IN_W-1:0]    right_in;
    logic               load;
    logic               shift_en;
    logic [LEFT_W-1:0]  left_out;
    logic [RIGHT_W-1:0] right_out;
    logic               right_lsb;
    logic               right_zero;

    logic [EXP_W-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    operand_shift_unit #(
        .IN_W    (IN_W),
        .LEFT_W  (LEFT_W),
        .RIGHT_W (RIGHT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .left_in    (left_in),
        .right_in   (right_in),
        .load       (load),
        .shift_en   (shift_en),
        .left_out   (left_out),
        .right_out  (right_out),
        .right_lsb  (right_lsb),
        .right_zero (right_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [EXP_W-1:0] exp_v);
        logic [EXP_W-1:0] got;
        got = {left_out, right_out, right_lsb, right_zero};
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got left=%h right=%h lsb=%b zero=%b, expected left=%h right=%h lsb=%b zero=%b",
                     name, got[EXP_W-1 -: LEFT_W], got[RIGHT_W+1:2], got[1], got[0],
                     exp_v[EXP_W-1 -: LEFT_W], exp_v[RIGHT_W+1:2], exp_v[1], exp_v[0]);
        end
    endtask

    // monitor: outputs are stable at the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check("queued", exp_q.pop_front());
        end
    end

    // driver: apply a command for one edge and queue the state expected after it
    task automatic step(input logic ld, input logic sh, input logic [IN_W-1:0] l, input logic [IN_W-1:0] r,
                        input logic [LEFT_W-1:0] e_left, input logic [RIGHT_W-1:0] e_right,
                        input logic e_lsb, input logic e_zero);
        @(negedge clk);
        load     = ld;
        shift_en = sh;
        left_in  = l;
        right_in = r;
        @(posedge clk);
        #1;
        exp_q.push_back({e_left, e_right, e_lsb, e_zero});
    endtask

    logic [LEFT_W-1:0]  ovf_left  [1:15];
    logic [RIGHT_W-1:0] ovf_right [1:15];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        load     = 1'b0;
        shift_en = 1'b0;
        left_in  = '0;
        right_in = '0;

        ovf_left = '{14'h01FE, 14'h03FC, 14'h07F8, 14'h0FF0, 14'h1FE0, 14'h3FC0, 14'h3F80,
                     14'h3F00, 14'h3E00, 14'h3C00, 14'h3800, 14'h3000, 14'h2000, 14'h0000, 14'h0000};
        ovf_right = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        #12;
        check("reset_held", {14'h0000, 8'h00, 1'b0, 1'b1});
        @(negedge clk);
        rst = 1'b0;

        // load and shift sequence
        step(1, 0, 8'hB5, 8'h0D, 14'h00B5, 8'h0D, 1, 0);
        step(0, 1, 8'h00, 8'h00, 14'h016A, 8'h06, 0, 0);
        step(0, 1, 8'h00, 8'h00, 14'h02D4, 8'h03, 1, 0);
        step(0, 1, 8'h00, 8'h00, 14'h05A8, 8'h01, 1, 0);
        step(0, 1, 8'h00, 8'h00, 14'h0B50, 8'h00, 0, 1);

        // load beats shift, then hold
        step(1, 1, 8'h01, 8'h80, 14'h0001, 8'h80, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'hAA, 8'h55, 14'h0001, 8'h80, 0, 0);
        end

        // overflow / saturation
        step(1, 0, 8'hFF, 8'hFF, 14'h00FF, 8'hFF, 1, 0);
        for (int i = 1; i <= 15; i++) begin
            step(0, 1, 8'h00, 8'h00, ovf_left[i], ovf_right[i], ovf_right[i][0], ovf_right[i] == 8'h00);
        end

        // zero multiplier finishes immediately
        step(1, 0, 8'h55, 8'h00, 14'h0055, 8'h00, 0, 1);

        // asynchronous reset between edges
        step(1, 0, 8'h12, 8'h35, 14'h0012, 8'h35, 1, 0);
        @(negedge clk);
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {14'h0000, 8'h00, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        check("reset_over_edge", {14'h0000, 8'h00, 1'b0, 1'b1});
        rst = 1'b0;
        step(0, 1, 8'hFF, 8'hFF, 14'h0000, 8'h00, 0, 1);
        step(1, 0, 8'h03, 8'h02, 14'h0003, 8'h02, 0, 0);

        // drain scoreboard with a bound
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
